// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared ATM cell constants and the Tx controller state type
package atm_pkg;

  localparam int ATM_CELL_BYTES = 53;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_CLAV,
    SEND
  } tx_state_e;

endpackage

// File: rtl/utopia_tx_ctrl_if.sv
// rtl/utopia_tx_ctrl_if.sv - switch-core byte stream in, UTOPIA Tx port out
interface utopia_tx_ctrl_if;
  logic [7:0] in_data;
  logic       in_soc;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_soc;
  logic       tx_en;
  logic       tx_clav;

  modport master (
    output in_data, in_soc, in_valid, tx_clav,
    input  in_ready, tx_data, tx_soc, tx_en
  );

  modport slave (
    input  in_data, in_soc, in_valid, tx_clav,
    output in_ready, tx_data, tx_soc, tx_en
  );
endinterface

// File: rtl/atm_cell_buf.sv
// rtl/atm_cell_buf.sv - one-cell byte store, single write port, registered read port
module atm_cell_buf
  import atm_pkg::*;
#(
  parameter int CELL_BYTES = ATM_CELL_BYTES,
  parameter int ADDR_W     = $clog2(CELL_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [CELL_BYTES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register doubles as the Tx data register, so it reads as zero when idle.
  always_ff @(posedge clk) begin
    if (rst || !rd_en) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/utopia_tx_ctrl.sv
// rtl/utopia_tx_ctrl.sv - buffers one ATM cell from the core and sends it whole when the PHY has room
module utopia_tx_ctrl
  import atm_pkg::*;
#(
  parameter int CELL_BYTES = ATM_CELL_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  utopia_tx_ctrl_if.slave bus,
  output logic [15:0]     cell_cnt,
  output logic [7:0]      drop_cnt
);

  localparam int IDX_W = $clog2(CELL_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_BYTES - 1);

  tx_state_e        state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] wr_addr;
  logic             accept, wr_en, rd_en, cell_done, drop_hit;
  logic             tx_soc_q, tx_en_q;
  logic [7:0]       rd_data;

  assign bus.in_ready = (state == IDLE) || (state == FILL);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // In FILL, idx holds the index of the last byte written; in SEND it is the read index.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_en     = 1'b0;
    wr_addr   = '0;
    rd_en     = 1'b0;
    cell_done = 1'b0;
    drop_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.in_soc) begin
            wr_en     = 1'b1;
            state_nxt = FILL;
          end else begin
            drop_hit = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (bus.in_soc) begin
            drop_hit = 1'b1;
            idx_nxt  = '0;
          end else begin
            wr_addr = idx + 1'b1;
            if (wr_addr == LAST_IDX) begin
              state_nxt = WAIT_CLAV;
              idx_nxt   = '0;
            end else begin
              idx_nxt = wr_addr;
            end
          end
        end
      end
      WAIT_CLAV: begin
        if (bus.tx_clav) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        rd_en = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cell_done = 1'b1;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  atm_cell_buf #(
    .CELL_BYTES(CELL_BYTES),
    .ADDR_W    (IDX_W)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(bus.in_data),
    .rd_en  (rd_en),
    .rd_addr(idx),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en_q  <= 1'b1;
      tx_soc_q <= 1'b0;
      cell_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      tx_en_q  <= !rd_en;
      tx_soc_q <= rd_en && (idx == '0);
      if (cell_done) begin
        cell_cnt <= cell_cnt + 16'd1;
      end
      if (drop_hit && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign bus.tx_en   = tx_en_q;
  assign bus.tx_soc  = tx_soc_q;
  assign bus.tx_data = rd_data;

endmodule

// File: tb/tb_utopia_tx_ctrl.sv
// tb/tb_utopia_tx_ctrl.sv - directed self-checking bench for utopia_tx_ctrl
module tb_utopia_tx_ctrl;
  import atm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cell_cnt;
  logic [7:0]  drop_cnt;
  int          compared = 0;
  int          mismatched = 0;

  logic [7:0]  cap_data [64];
  logic        cap_soc  [64];
  int          cap_n, cap_wait;
  int          fill_tx_low, fill_not_ready;

  utopia_tx_ctrl_if bus ();

  utopia_tx_ctrl #(.CELL_BYTES(53)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cell_cnt(cell_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int seed, input int step, input int i);
    return 8'(seed + i * step);
  endfunction

  task automatic fill(input int n, input int seed, input int step);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_soc   = (i == 0);
      bus.in_data  = pat(seed, step, i);
      if (bus.tx_en !== 1'b1) fill_tx_low++;
      if (bus.in_ready !== 1'b1) fill_not_ready++;
      tick;
    end
    bus.in_valid = 1'b0;
    bus.in_soc   = 1'b0;
  endtask

  // Waits for the first tx_en=0 cycle, then records the burst until tx_en returns to 1.
  task automatic collect(input int drop_at);
    cap_n = 0;
    cap_wait = 0;
    for (int w = 1; w <= 40; w++) begin
      tick;
      if (bus.tx_en === 1'b0) begin
        cap_wait = w;
        break;
      end
    end
    while (cap_wait != 0 && bus.tx_en === 1'b0 && cap_n < 64) begin
      cap_data[cap_n] = bus.tx_data;
      cap_soc[cap_n]  = bus.tx_soc;
      if (cap_n == drop_at) bus.tx_clav = 1'b0;
      cap_n++;
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    compared++;
    if (bus.tx_en !== 1'b1 || bus.tx_soc !== 1'b0 || bus.tx_data !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_tx: got en=%b soc=%b data=%h expected en=1 soc=0 data=00", bus.tx_en, bus.tx_soc, bus.tx_data);
    end
    compared++;
    if (cell_cnt !== 16'd0 || drop_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_cnt: got cell=%0d drop=%0d expected 0/0", cell_cnt, drop_cnt);
    end
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got %b expected 1", bus.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_cell;
    bus.tx_clav = 1'b1;
    fill_tx_low = 0;
    fill_not_ready = 0;
    fill(53, 0, 1);
    compared++;
    if (fill_not_ready != 0 || fill_tx_low != 0) begin
      mismatched++;
      $display("FAIL single_fill: got not_ready=%0d tx_low=%0d expected 0/0", fill_not_ready, fill_tx_low);
    end
    compared++;
    if (bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL single_ready_full: got %b expected 0", bus.in_ready);
    end
    collect(-1);
    compared++;
    if (cap_wait != 2 || cap_n != 53) begin
      mismatched++;
      $display("FAIL single_len: got wait=%0d n=%0d expected 2/53", cap_wait, cap_n);
    end
    for (int i = 0; i < 53; i++) begin
      compared++;
      if (cap_data[i] !== pat(0, 1, i) || cap_soc[i] !== (i == 0)) begin
        mismatched++;
        $display("FAIL single_byte[%0d]: got %h/%b expected %h/%b", i, cap_data[i], cap_soc[i], pat(0, 1, i), i == 0);
      end
    end
    compared++;
    if (bus.tx_en !== 1'b1 || bus.tx_soc !== 1'b0 || bus.tx_data !== 8'h00 || cell_cnt !== 16'd1) begin
      mismatched++;
      $display("FAIL single_end: got en=%b soc=%b data=%h cell=%0d expected 1/0/00/1", bus.tx_en, bus.tx_soc, bus.tx_data, cell_cnt);
    end
  endtask

  task automatic test_clav_hold;
    int bad;
    bad = 0;
    bus.tx_clav = 1'b0;
    fill(53, 7, 3);
    for (int c = 0; c < 20; c++) begin
      if (bus.tx_en !== 1'b1 || bus.in_ready !== 1'b0) bad++;
      tick;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL clav_hold_idle: got %0d bad cycles expected 0", bad);
    end
    bus.tx_clav = 1'b1;
    collect(-1);
    compared++;
    if (cap_wait != 2 || cap_n != 53) begin
      mismatched++;
      $display("FAIL clav_hold_len: got wait=%0d n=%0d expected 2/53", cap_wait, cap_n);
    end
    for (int i = 0; i < 53; i++) begin
      compared++;
      if (cap_data[i] !== pat(7, 3, i) || cap_soc[i] !== (i == 0)) begin
        mismatched++;
        $display("FAIL clav_hold_byte[%0d]: got %h/%b expected %h/%b", i, cap_data[i], cap_soc[i], pat(7, 3, i), i == 0);
      end
    end
    compared++;
    if (cell_cnt !== 16'd2) begin
      mismatched++;
      $display("FAIL clav_hold_cnt: got %0d expected 2", cell_cnt);
    end
  endtask

  task automatic test_clav_drop;
    bus.tx_clav = 1'b1;
    fill(53, 8'h90, 5);
    collect(10);
    compared++;
    if (cap_wait != 2 || cap_n != 53) begin
      mismatched++;
      $display("FAIL clav_drop_len: got wait=%0d n=%0d expected 2/53", cap_wait, cap_n);
    end
    for (int i = 0; i < 53; i++) begin
      compared++;
      if (cap_data[i] !== pat(8'h90, 5, i) || cap_soc[i] !== (i == 0)) begin
        mismatched++;
        $display("FAIL clav_drop_byte[%0d]: got %h/%b expected %h/%b", i, cap_data[i], cap_soc[i], pat(8'h90, 5, i), i == 0);
      end
    end
    compared++;
    if (cell_cnt !== 16'd3) begin
      mismatched++;
      $display("FAIL clav_drop_cnt: got %0d expected 3", cell_cnt);
    end
    bus.tx_clav = 1'b1;
  endtask

  task automatic test_back_to_back;
    int soc_at [2];
    int nsoc, nlow, bad_data, bad_idle;
    logic [15:0] c0;
    nsoc = 0;
    nlow = 0;
    bad_data = 0;
    bad_idle = 0;
    soc_at[0] = -1;
    soc_at[1] = -1;
    c0 = cell_cnt;
    bus.tx_clav = 1'b1;
    fork
      begin
        int b;
        logic rdy;
        b = 0;
        for (int g = 0; g < 400 && b < 106; g++) begin
          bus.in_valid = 1'b1;
          bus.in_soc   = (b % 53 == 0);
          bus.in_data  = 8'(b);
          rdy = bus.in_ready;
          tick;
          if (rdy) b++;
        end
        bus.in_valid = 1'b0;
        bus.in_soc   = 1'b0;
      end
      begin
        for (int c = 0; c < 260; c++) begin
          tick;
          if (bus.tx_en === 1'b0) begin
            if (bus.tx_data !== 8'(nlow)) bad_data++;
            if (bus.tx_soc === 1'b1) begin
              if (nsoc < 2) soc_at[nsoc] = c;
              nsoc++;
            end
            nlow++;
          end else if (bus.tx_data !== 8'h00 || bus.tx_soc !== 1'b0) begin
            bad_idle++;
          end
        end
      end
    join
    compared++;
    if (nlow != 106 || nsoc != 2 || bad_data != 0) begin
      mismatched++;
      $display("FAIL b2b_bytes: got low=%0d soc=%0d bad=%0d expected 106/2/0", nlow, nsoc, bad_data);
    end
    compared++;
    if (soc_at[0] != 54 || soc_at[1] - soc_at[0] != 107) begin
      mismatched++;
      $display("FAIL b2b_spacing: got first=%0d delta=%0d expected 54/107", soc_at[0], soc_at[1] - soc_at[0]);
    end
    compared++;
    if (bad_idle != 0) begin
      mismatched++;
      $display("FAIL b2b_idle_zero: got %0d bad cycles expected 0", bad_idle);
    end
    compared++;
    if (cell_cnt !== c0 + 16'd2) begin
      mismatched++;
      $display("FAIL b2b_cnt: got %0d expected %0d", cell_cnt, c0 + 16'd2);
    end
  endtask

  task automatic test_resync;
    bus.tx_clav = 1'b1;
    fill_tx_low = 0;
    fill(30, 8'h40, 3);
    fill(53, 8'h11, 9);
    compared++;
    if (drop_cnt !== 8'd1 || fill_tx_low != 0) begin
      mismatched++;
      $display("FAIL resync_drop: got drop=%0d tx_low=%0d expected 1/0", drop_cnt, fill_tx_low);
    end
    collect(-1);
    compared++;
    if (cap_wait != 2 || cap_n != 53) begin
      mismatched++;
      $display("FAIL resync_len: got wait=%0d n=%0d expected 2/53", cap_wait, cap_n);
    end
    for (int i = 0; i < 53; i++) begin
      compared++;
      if (cap_data[i] !== pat(8'h11, 9, i) || cap_soc[i] !== (i == 0)) begin
        mismatched++;
        $display("FAIL resync_byte[%0d]: got %h/%b expected %h/%b", i, cap_data[i], cap_soc[i], pat(8'h11, 9, i), i == 0);
      end
    end
    compared++;
    if (cell_cnt !== 16'd6) begin
      mismatched++;
      $display("FAIL resync_cnt: got %0d expected 6", cell_cnt);
    end
  endtask

  task automatic test_reset_mid_send;
    int w;
    bus.tx_clav = 1'b1;
    fill(53, 8'h23, 11);
    w = 0;
    while (bus.tx_en !== 1'b0 && w < 10) begin
      tick;
      w++;
    end
    for (int i = 0; i < 20; i++) tick;
    compared++;
    if (bus.tx_en !== 1'b0 || bus.tx_data !== pat(8'h23, 11, 20)) begin
      mismatched++;
      $display("FAIL midsend_byte20: got en=%b data=%h expected 0/%h", bus.tx_en, bus.tx_data, pat(8'h23, 11, 20));
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    compared++;
    if (bus.tx_en !== 1'b1 || bus.tx_soc !== 1'b0 || bus.tx_data !== 8'h00 || cell_cnt !== 16'd0 || drop_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL midsend_reset: got en=%b soc=%b data=%h cell=%0d drop=%0d expected 1/0/00/0/0", bus.tx_en, bus.tx_soc, bus.tx_data, cell_cnt, drop_cnt);
    end
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL midsend_ready: got %b expected 1", bus.in_ready);
    end
    fill(53, 8'hC8, 13);
    collect(-1);
    compared++;
    if (cap_wait != 2 || cap_n != 53) begin
      mismatched++;
      $display("FAIL midsend_len: got wait=%0d n=%0d expected 2/53", cap_wait, cap_n);
    end
    for (int i = 0; i < 53; i++) begin
      compared++;
      if (cap_data[i] !== pat(8'hC8, 13, i) || cap_soc[i] !== (i == 0)) begin
        mismatched++;
        $display("FAIL midsend_byte[%0d]: got %h/%b expected %h/%b", i, cap_data[i], cap_soc[i], pat(8'hC8, 13, i), i == 0);
      end
    end
    compared++;
    if (cell_cnt !== 16'd1) begin
      mismatched++;
      $display("FAIL midsend_cnt: got %0d expected 1", cell_cnt);
    end
  endtask

  task automatic test_orphans;
    int tx_low;
    tx_low = 0;
    bus.tx_clav = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_soc = 1'b0;
    bus.in_data = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (bus.tx_en !== 1'b1) tx_low++;
    end
    compared++;
    if (drop_cnt !== 8'd5 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL orphan_5: got drop=%0d ready=%b expected 5/1", drop_cnt, bus.in_ready);
    end
    for (int i = 0; i < 249; i++) begin
      tick;
      if (bus.tx_en !== 1'b1) tx_low++;
    end
    compared++;
    if (drop_cnt !== 8'hFE) begin
      mismatched++;
      $display("FAIL orphan_254: got %h expected fe", drop_cnt);
    end
    tick;
    compared++;
    if (drop_cnt !== 8'hFF) begin
      mismatched++;
      $display("FAIL orphan_255: got %h expected ff", drop_cnt);
    end
    for (int i = 0; i < 45; i++) begin
      tick;
      if (bus.tx_en !== 1'b1) tx_low++;
    end
    bus.in_valid = 1'b0;
    compared++;
    if (drop_cnt !== 8'hFF) begin
      mismatched++;
      $display("FAIL orphan_sat: got %h expected ff", drop_cnt);
    end
    compared++;
    if (tx_low != 0 || cell_cnt !== 16'd1) begin
      mismatched++;
      $display("FAIL orphan_no_tx: got tx_low=%0d cell=%0d expected 0/1", tx_low, cell_cnt);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_soc   = 1'b0;
    bus.in_data  = 8'h00;
    bus.tx_clav  = 1'b0;
    test_reset;
    test_single_cell;
    test_clav_hold;
    test_clav_drop;
    test_back_to_back;
    test_resync;
    test_reset_mid_send;
    test_orphans;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
